sc_level_progress: RTL and testbench
====================================

SC_LEVEL_PROGRESS -- requirements
Module: sc_level_progress

Interface
REQ-001 The parameter LEVEL_WIDTH SHALL default to 3 and set the width of the level number.
REQ-002 The parameter PROGRESS_WIDTH SHALL default to 5 and set the width of the progress counter.
REQ-003 The parameter PROGRESS_TARGET SHALL default to 12 (5'b01100) and set the number of advances needed to finish a level.
REQ-004 The parameter MAX_LEVEL SHALL default to 3 and set the last playable level.
REQ-005 The port SC_LEVEL_STATEMACHINE_CLOCK_50 SHALL be an input, 1 bit wide, and carry the 50 MHz system clock; all state changes occur on its rising edge.
REQ-006 The port SC_LEVEL_STATEMACHINE_RESET_InHigh SHALL be an input, 1 bit wide, and act as an asynchronous, active-high reset.
REQ-007 The port Start_In SHALL be an input, 1 bit wide, and request game start (level input, rising-edge detected).
REQ-008 The port FrogAdvance_In SHALL be an input, 1 bit wide, and signal that the frog has advanced one row (level input, rising-edge detected).
REQ-009 The port FrogDeath_In SHALL be an input, 1 bit wide, and signal that the frog has died (level input, rising-edge detected).
REQ-010 The port LevelFinished_In SHALL be an input, 1 bit wide, and carry the level-finished flag from the level state machine.
REQ-011 The port StartCount_In SHALL be an input, 1 bit wide, and carry the count-hold flag from the level state machine; while it is 1, advance counting is blocked.
REQ-012 The port CurrentLevel_Out SHALL be an output, LEVEL_WIDTH bits wide, and drive the level number to the level state machine.
REQ-013 The port LvlProgressCount_Out SHALL be an output, PROGRESS_WIDTH bits wide, and drive the progress count to the level state machine.
REQ-014 The port LevelUp_Out SHALL be an output, 1 bit wide, and pulse for one cycle on each level increment.
REQ-015 The port GameDone_Out SHALL be an output, 1 bit wide, and be high while in the DONE state.

Function
REQ-016 Rising-edge detection SHALL use one previous-sample register per detected input: edge = in & ~prev; each prev register resets to 0.
REQ-017 The block SHALL implement four states: IDLE, PLAY, ADVANCE and DONE, all with registered outputs.
REQ-018 In IDLE, a Start_In edge SHALL set CurrentLevel_Out to 1, clear progress to 0 and move to PLAY at the same clock edge; all other inputs SHALL be ignored.
REQ-019 In PLAY, a FrogAdvance_In edge with StartCount_In=0 and progress<PROGRESS_TARGET SHALL increment progress by 1 at that edge.
REQ-020 Progress SHALL saturate at PROGRESS_TARGET; further advance edges SHALL leave it unchanged and SHALL never wrap.
REQ-021 In PLAY, a FrogDeath_In edge SHALL clear progress to 0, and SHALL take priority over a simultaneous advance edge.
REQ-022 In PLAY, when LevelFinished_In=1 and progress==PROGRESS_TARGET are sampled together, the block SHALL enter ADVANCE on the next edge; a death edge in that same cycle SHALL clear progress and cancel the transition.
REQ-023 LevelFinished_In=1 while progress!=PROGRESS_TARGET SHALL be ignored.
REQ-024 In ADVANCE, which lasts exactly one cycle, the block SHALL increment the level by 1, clear progress to 0, assert LevelUp_Out=1 for that one cycle, and go to DONE if the new level is MAX_LEVEL+1, else to PLAY.
REQ-025 In DONE, CurrentLevel_Out SHALL hold MAX_LEVEL+1 (4), progress SHALL hold 0 and GameDone_Out SHALL be 1; all inputs SHALL be ignored, and only reset SHALL exit DONE.
REQ-026 CurrentLevel_Out SHALL never exceed MAX_LEVEL+1.
REQ-027 Edges occurring in ADVANCE SHALL be discarded; the prev registers SHALL still update.
REQ-028 Latency from an input edge to an output change SHALL be one clock edge; from qualified finish to LevelUp_Out SHALL be one edge; from qualified finish to the new level value SHALL be two edges.

Reset
REQ-029 Reset asserted at any time, including mid-level or in ADVANCE, SHALL immediately force IDLE with CurrentLevel_Out=0, LvlProgressCount_Out=0, LevelUp_Out=0, GameDone_Out=0 and all prev registers at 0.
REQ-030 After reset release, an input already held high SHALL register as an edge on the first clock edge.

Verification
REQ-031 The bench SHALL cover: reset, then Start_In pulse -> level=1, progress=0, state PLAY.
REQ-032 The bench SHALL cover: 14 FrogAdvance_In pulses with StartCount_In=0 -> progress 1..12, then holding at 12.
REQ-033 The bench SHALL cover: progress=5, FrogAdvance_In and FrogDeath_In rising in the same cycle -> progress=0.
REQ-034 The bench SHALL cover: progress=12 with LevelFinished_In=1 -> one cycle later LevelUp_Out=1; the next cycle level=2 and progress=0.
REQ-035 The bench SHALL cover: completing level 3 -> level=4, GameDone_Out=1; further Start_In and advance pulses cause no change.
REQ-036 The bench SHALL cover: reset asserted at level 2, progress 7, asynchronous to the clock -> outputs at 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/sc_level_progress.sv
// ---------------------------------------------------------------------------
// sc_level_progress
//   Tracks the frog's level and its progress through that level. Start begins
//   level 1. Each frog advance counts one row, saturating at PROGRESS_TARGET,
//   and a death sends progress back to 0. A finish reported while progress is
//   at target spends one ADVANCE cycle: LevelUp_Out pulses during that cycle
//   and the level increments at its end. Finishing MAX_LEVEL parks the block
//   in DONE until reset.
//
// Ports
//   SC_LEVEL_STATEMACHINE_CLOCK_50     in   50 MHz clock, rising edge
//   SC_LEVEL_STATEMACHINE_RESET_InHigh in   async reset, active high
//   Start_In                           in   game start (edge detected)
//   FrogAdvance_In                     in   frog moved one row (edge detected)
//   FrogDeath_In                       in   frog died (edge detected)
//   LevelFinished_In                   in   level-finished flag
//   StartCount_In                      in   1 = hold, advances not counted
//   CurrentLevel_Out   [LEVEL_WIDTH]   out  level number (0 = not started)
//   LvlProgressCount_Out [PROGRESS_WIDTH] out  rows advanced this level
//   LevelUp_Out                        out  one-cycle pulse per level increment
//   GameDone_Out                       out  high in DONE
// ---------------------------------------------------------------------------
module sc_level_progress #(
  parameter int LEVEL_WIDTH     = 3,
  parameter int PROGRESS_WIDTH  = 5,
  parameter int PROGRESS_TARGET = 12,
  parameter int MAX_LEVEL       = 3
) (
  input  logic                      SC_LEVEL_STATEMACHINE_CLOCK_50,
  input  logic                      SC_LEVEL_STATEMACHINE_RESET_InHigh,
  input  logic                      Start_In,
  input  logic                      FrogAdvance_In,
  input  logic                      FrogDeath_In,
  input  logic                      LevelFinished_In,
  input  logic                      StartCount_In,
  output logic [LEVEL_WIDTH-1:0]    CurrentLevel_Out,
  output logic [PROGRESS_WIDTH-1:0] LvlProgressCount_Out,
  output logic                      LevelUp_Out,
  output logic                      GameDone_Out
);

  localparam logic [PROGRESS_WIDTH-1:0] TARGET    = PROGRESS_WIDTH'(PROGRESS_TARGET);
  localparam logic [LEVEL_WIDTH-1:0]    LVL_FIRST = LEVEL_WIDTH'(1);
  localparam logic [LEVEL_WIDTH-1:0]    LVL_LAST  = LEVEL_WIDTH'(MAX_LEVEL);
  localparam logic [LEVEL_WIDTH-1:0]    LVL_FINAL = LEVEL_WIDTH'(MAX_LEVEL + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_ADVANCE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [LEVEL_WIDTH-1:0]    level_q, level_d;
  logic [PROGRESS_WIDTH-1:0] prog_q,  prog_d;
  logic                      lvlup_q, lvlup_d;
  logic                      done_q,  done_d;

  // Previous samples, bit order {death, advance, start}. They update every
  // cycle regardless of state, so an edge that lands in ADVANCE is consumed
  // and not seen again later.
  logic [2:0] prev_q;
  logic [2:0] in_vec;
  logic [2:0] edge_w;
  logic       start_e, adv_e, death_e;

  assign in_vec  = {FrogDeath_In, FrogAdvance_In, Start_In};
  assign edge_w  = in_vec & ~prev_q;
  assign start_e = edge_w[0];
  assign adv_e   = edge_w[1];
  assign death_e = edge_w[2];

  always_ff @(posedge SC_LEVEL_STATEMACHINE_CLOCK_50 or
              posedge SC_LEVEL_STATEMACHINE_RESET_InHigh) begin
    if (SC_LEVEL_STATEMACHINE_RESET_InHigh) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      prog_q  <= '0;
      lvlup_q <= 1'b0;
      done_q  <= 1'b0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      prog_q  <= prog_d;
      lvlup_q <= lvlup_d;
      done_q  <= done_d;
      prev_q  <= in_vec;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    prog_d  = prog_q;
    lvlup_d = 1'b0;
    done_d  = done_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_e) begin
          level_d = LVL_FIRST;
          prog_d  = '0;
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // Death wins over both a simultaneous advance and a qualified finish.
        if (death_e) begin
          prog_d = '0;
        end else if (LevelFinished_In && (prog_q == TARGET)) begin
          state_d = ST_ADVANCE;
          lvlup_d = 1'b1;
        end else if (adv_e && !StartCount_In && (prog_q < TARGET)) begin
          prog_d = prog_q + PROGRESS_WIDTH'(1);
        end
      end
      ST_ADVANCE: begin
        // LevelUp_Out is high during this cycle; the new level lands at its end.
        level_d = level_q + LEVEL_WIDTH'(1);
        prog_d  = '0;
        if (level_q == LVL_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_DONE: begin
        level_d = LVL_FINAL;
        prog_d  = '0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        level_d = '0;
        prog_d  = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign CurrentLevel_Out     = level_q;
  assign LvlProgressCount_Out = prog_q;
  assign LevelUp_Out          = lvlup_q;
  assign GameDone_Out         = done_q;

endmodule

// File: tb/tb_sc_level_progress.sv
module tb_sc_level_progress;

  localparam int TGT  = 12;
  localparam int MAXL = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, adv = 1'b0, death = 1'b0, lf = 1'b0, sc = 1'b0;
  logic [2:0] lvl;
  logic [4:0] prog;
  logic       lvlup, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: game-level view (started / in level-up cycle / finished).
  int m_lvl, m_prog;
  bit m_up, m_done, m_run;
  bit pS, pA, pD;

  sc_level_progress dut (
    .SC_LEVEL_STATEMACHINE_CLOCK_50     (clk),
    .SC_LEVEL_STATEMACHINE_RESET_InHigh (rst),
    .Start_In                           (start),
    .FrogAdvance_In                     (adv),
    .FrogDeath_In                       (death),
    .LevelFinished_In                   (lf),
    .StartCount_In                      (sc),
    .CurrentLevel_Out                   (lvl),
    .LvlProgressCount_Out               (prog),
    .LevelUp_Out                        (lvlup),
    .GameDone_Out                       (done)
  );

  always #10 clk = ~clk;

  task automatic model_reset();
    m_lvl = 0; m_prog = 0; m_up = 0; m_done = 0; m_run = 0;
    pS = 0; pA = 0; pD = 0;
  endtask

  task automatic model_step();
    bit es, ea, ed;
    if (rst) begin
      model_reset();
      return;
    end
    es = start & !pS; ea = adv & !pA; ed = death & !pD;
    if (m_done) begin
    end else if (m_up) begin
      m_lvl++; m_prog = 0; m_up = 0;
      if (m_lvl == MAXL + 1) m_done = 1;
    end else if (!m_run) begin
      if (es) begin m_run = 1; m_lvl = 1; m_prog = 0; end
    end else if (ed) begin
      m_prog = 0;
    end else if (lf && m_prog == TGT) begin
      m_up = 1;
    end else if (ea && !sc && m_prog < TGT) begin
      m_prog++;
    end
    pS = start; pA = adv; pD = death;
  endtask

  // One clock: inputs were set at the preceding negedge; returns at the next.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic pulse_adv(input int n);
    for (int i = 0; i < n; i++) begin
      adv = 1; tick(); adv = 0; tick();
    end
  endtask

  task automatic finish_level();
    pulse_adv(TGT);
    lf = 1; tick(); lf = 0; tick();
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (lvl !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", lvl); end
    n_checks++; if (prog !== 5'd0) begin n_fail++; $display("FAIL reset_prog got=%0d exp=0", prog); end
    n_checks++; if (lvlup !== 1'b0) begin n_fail++; $display("FAIL reset_levelup got=%b exp=0", lvlup); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
  endtask

  task automatic test_start();
    // Inputs other than start are ignored in IDLE.
    adv = 1; death = 1; lf = 1; tick(); adv = 0; death = 0; lf = 0; tick();
    n_checks++; if (lvl !== 3'd0 || prog !== 5'd0) begin n_fail++; $display("FAIL idle_ignore got=%0d/%0d exp=0/0", lvl, prog); end
    start = 1; tick();
    n_checks++; if (lvl !== 3'd1) begin n_fail++; $display("FAIL start_level got=%0d exp=1", lvl); end
    n_checks++; if (prog !== 5'd0) begin n_fail++; $display("FAIL start_prog got=%0d exp=0", prog); end
    start = 0; tick();
  endtask

  task automatic test_advance_sat();
    for (int i = 1; i <= 14; i++) begin
      adv = 1; tick();
      n_checks++;
      if (prog !== 5'((i < TGT) ? i : TGT)) begin
        n_fail++; $display("FAIL advance_%0d got=%0d exp=%0d", i, prog, (i < TGT) ? i : TGT);
      end
      adv = 0; tick();
    end
  endtask

  task automatic test_death();
    death = 1; tick(); death = 0; tick();
    n_checks++; if (prog !== 5'd0) begin n_fail++; $display("FAIL death_clear got=%0d exp=0", prog); end
    pulse_adv(5);
    n_checks++; if (prog !== 5'd5) begin n_fail++; $display("FAIL five_adv got=%0d exp=5", prog); end
    sc = 1; pulse_adv(2); sc = 0;
    n_checks++; if (prog !== 5'd5) begin n_fail++; $display("FAIL hold_blocks got=%0d exp=5", prog); end
    adv = 1; death = 1; tick();
    n_checks++; if (prog !== 5'd0) begin n_fail++; $display("FAIL death_priority got=%0d exp=0", prog); end
    adv = 0; death = 0; tick();
  endtask

  task automatic test_levelup();
    pulse_adv(TGT - 1);
    lf = 1; tick();
    n_checks++; if (lvlup !== 1'b0 || prog !== 5'd11) begin n_fail++; $display("FAIL finish_early got=%b/%0d exp=0/11", lvlup, prog); end
    lf = 0; pulse_adv(1);
    // Death in the qualifying cycle cancels the level-up.
    lf = 1; death = 1; tick();
    n_checks++; if (lvlup !== 1'b0 || prog !== 5'd0) begin n_fail++; $display("FAIL finish_cancel got=%b/%0d exp=0/0", lvlup, prog); end
    lf = 0; death = 0; tick();
    pulse_adv(TGT);
    lf = 1; tick();
    n_checks++; if (lvlup !== 1'b1 || lvl !== 3'd1) begin n_fail++; $display("FAIL levelup_pulse got=%b/%0d exp=1/1", lvlup, lvl); end
    lf = 0; adv = 1; tick(); // edge inside ADVANCE is discarded
    n_checks++; if (lvlup !== 1'b0 || lvl !== 3'd2 || prog !== 5'd0) begin n_fail++; $display("FAIL level2 got=%b/%0d/%0d exp=0/2/0", lvlup, lvl, prog); end
    adv = 0; tick();
    n_checks++; if (prog !== 5'd0) begin n_fail++; $display("FAIL adv_discard got=%0d exp=0", prog); end
  endtask

  task automatic test_done();
    finish_level();
    n_checks++; if (lvl !== 3'd3 || done !== 1'b0) begin n_fail++; $display("FAIL level3 got=%0d/%b exp=3/0", lvl, done); end
    finish_level();
    n_checks++; if (lvl !== 3'd4 || done !== 1'b1 || prog !== 5'd0) begin n_fail++; $display("FAIL game_done got=%0d/%b/%0d exp=4/1/0", lvl, done, prog); end
    start = 1; tick(); start = 0; tick();
    pulse_adv(3);
    lf = 1; death = 1; tick(); lf = 0; death = 0; tick();
    n_checks++; if (lvl !== 3'd4 || done !== 1'b1 || prog !== 5'd0 || lvlup !== 1'b0) begin
      n_fail++; $display("FAIL done_hold got=%0d/%b/%0d/%b exp=4/1/0/0", lvl, done, prog, lvlup);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    start = 1; tick(); start = 0; tick();
    finish_level();
    pulse_adv(7);
    n_checks++; if (lvl !== 3'd2 || prog !== 5'd7) begin n_fail++; $display("FAIL pre_reset got=%0d/%0d exp=2/7", lvl, prog); end
    #3 rst = 1;
    #1;
    n_checks++; if (lvl !== 3'd0 || prog !== 5'd0 || lvlup !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got=%0d/%0d/%b/%b exp=0/0/0/0", lvl, prog, lvlup, done);
    end
    start = 1; // held through release: counts as an edge on first clock
    tick(); rst = 0; tick();
    n_checks++; if (lvl !== 3'd1) begin n_fail++; $display("FAIL held_start got=%0d exp=1", lvl); end
    start = 0; tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 599) == 0);
      start = ($urandom_range(0, 15) == 0);
      adv   = ~adv & ($urandom_range(0, 3) != 0);
      death = ($urandom_range(0, 79) == 0);
      lf    = $urandom_range(0, 1);
      sc    = ($urandom_range(0, 7) == 0);
      tick();
      n_checks++;
      if (lvl !== 3'(m_lvl) || prog !== 5'(m_prog) || lvlup !== m_up || done !== m_done) begin
        n_fail++;
        $display("FAIL random_c%0d got lvl=%0d prog=%0d up=%b done=%b exp lvl=%0d prog=%0d up=%b done=%b",
                 c, lvl, prog, lvlup, done, m_lvl, m_prog, m_up, m_done);
      end
    end
    rst = 0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_start();
    test_advance_sat();
    test_death();
    test_levelup();
    test_done();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
